text_write_ctrl: RTL and testbench

TEXT_WRITE_CTRL -- requirements
Module: text_write_ctrl

---
 rtl/text_write_ctrl_pkg.sv | 33 +++
 rtl/text_write_ctrl_if.sv | 31 +++
 rtl/text_cursor.sv | 58 +++++
 rtl/text_write_ctrl.sv | 153 +++++++++++++++
 tb/tb_text_write_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/text_write_ctrl_pkg.sv
// Shared character codes, FSM encoding and character classification
// for the text-mode write controller.
package text_pkg;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    CC_PRINT,
    CC_LF,
    CC_CR,
    CC_BS,
    CC_OTHER
  } char_class_t;

  function automatic char_class_t classify(input logic [7:0] c);
    if ((c >= CH_PRINT_LO) && (c <= CH_PRINT_HI)) return CC_PRINT;
    else if (c == CH_LF)                          return CC_LF;
    else if (c == CH_CR)                          return CC_CR;
    else if (c == CH_BS)                          return CC_BS;
    else                                          return CC_OTHER;
  endfunction

endpackage

// File: rtl/text_write_ctrl_if.sv
// Character input handshake plus text-buffer write port.
interface text_write_ctrl_if #(
  parameter int AW = 15
);

  logic          in_valid;
  logic [7:0]    in_char;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;

  modport master (
    output in_valid,
    output in_char,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_din
  );

  modport slave (
    input  in_valid,
    input  in_char,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_din
  );

endinterface

// File: rtl/text_cursor.sv
// Cursor column/row counters with wrap-around and a linear cell address.
module text_cursor #(
  parameter int COLS = 160,
  parameter int ROWS = 128,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS),
  parameter int AW   = $clog2(COLS * ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic          retreat,
  input  logic          newline,
  input  logic          home,
  input  logic          col0,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic          at_origin
);

  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (home) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end else if (retreat) begin
      // At the origin retreat holds; the controller never requests it there.
      if (x != '0) begin
        x <= x - 1'b1;
      end else if (y != '0) begin
        x <= X_LAST;
        y <= y - 1'b1;
      end
    end else if (newline) begin
      x <= '0;
      y <= (y == Y_LAST) ? '0 : y + 1'b1;
    end else if (col0) begin
      x <= '0;
    end
  end

  assign addr      = AW'(y) * AW'(COLS) + AW'(x);
  assign at_origin = (x == '0) && (y == '0);

endmodule

// File: rtl/text_write_ctrl.sv
// Text-mode write controller: places characters at a wrapping cursor in a
// COLSxROWS text buffer and sweeps the buffer with spaces on a clear request.
module text_write_ctrl
  import text_pkg::*;
#(
  parameter  int H_DISP = 1280,
  parameter  int V_DISP = 1024,
  localparam int COLS   = H_DISP / 8,
  localparam int ROWS   = V_DISP / 8,
  localparam int CELLS  = COLS * ROWS,
  localparam int AW     = $clog2(CELLS),
  localparam int XW     = $clog2(COLS),
  localparam int YW     = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_req,
  output logic            busy,
  output logic [XW-1:0]   cursor_x,
  output logic [YW-1:0]   cursor_y,
  text_write_ctrl_if.slave bus
);

  localparam logic [AW-1:0] CNT_LAST = AW'(CELLS - 1);

  state_t        state, state_nx;
  logic [AW-1:0] clr_cnt, clr_cnt_nx;

  logic          in_ready;
  logic          accept;
  char_class_t   cls;

  logic          adv, ret, nl, cr, home;
  logic [AW-1:0] cur_addr;
  logic          at_origin;

  logic          vld_p0;
  logic [AW-1:0] addr_p0;
  logic [7:0]    din_p0;
  logic          vld_p1;
  logic [AW-1:0] addr_p1;
  logic [7:0]    din_p1;

  assign in_ready = reset && (state == IDLE) && !clear_req;
  assign accept   = bus.in_valid && in_ready;
  assign cls      = classify(bus.in_char);

  text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS),
    .XW   (XW),
    .YW   (YW),
    .AW   (AW)
  ) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .advance   (adv),
    .retreat   (ret),
    .newline   (nl),
    .home      (home),
    .col0      (cr),
    .x         (cursor_x),
    .y         (cursor_y),
    .addr      (cur_addr),
    .at_origin (at_origin)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    adv        = 1'b0;
    ret        = 1'b0;
    nl         = 1'b0;
    cr         = 1'b0;
    home       = 1'b0;
    vld_p0     = 1'b0;
    addr_p0    = '0;
    din_p0     = '0;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nx   = CLEAR;
          clr_cnt_nx = '0;
        end else if (accept) begin
          case (cls)
            CC_PRINT: begin
              vld_p0  = 1'b1;
              addr_p0 = cur_addr;
              din_p0  = bus.in_char;
              adv     = 1'b1;
            end
            CC_LF: nl = 1'b1;
            CC_CR: cr = 1'b1;
            CC_BS: begin
              // Both retreat cases (x-1, or last column of the row above)
              // land on the linear address one below the current one.
              if (!at_origin) begin
                ret     = 1'b1;
                vld_p0  = 1'b1;
                addr_p0 = cur_addr - 1'b1;
                din_p0  = CH_SPACE;
              end
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        vld_p0  = 1'b1;
        addr_p0 = clr_cnt;
        din_p0  = CH_SPACE;
        if (clr_cnt == CNT_LAST) begin
          state_nx   = IDLE;
          clr_cnt_nx = '0;
          home       = 1'b1;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0 -> p1: registered buffer write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      din_p1  <= '0;
    end else begin
      vld_p1  <= vld_p0;
      addr_p1 <= addr_p0;
      din_p1  <= din_p0;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.mem_we   = vld_p1;
  assign bus.mem_addr = addr_p1;
  assign bus.mem_din  = din_p1;
  assign busy         = (state == CLEAR);

endmodule

// File: tb/tb_text_write_ctrl.sv
// Randomized bench for text_write_ctrl against a linear-position reference model.
module tb_text_write_ctrl;

  localparam int COLS  = 160;
  localparam int ROWS  = 128;
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear_req = 1'b0;
  logic       busy;
  logic [7:0] cursor_x;
  logic [6:0] cursor_y;

  text_write_ctrl_if #(.AW(AW)) bus ();

  text_write_ctrl #(
    .H_DISP (1280),
    .V_DISP (1024)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: cursor kept as a linear cell index.
  int mpos   = 0;
  int m_cnt  = 0;
  bit m_busy = 1'b0;
  bit e_we   = 1'b0;
  bit e_data = 1'b0;
  int e_addr = 0;
  int e_din  = 0;
  int seen_we   = 0;
  int seen_busy = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 126));
  endfunction

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50)      return rand_print();
    else if (r < 60) return 8'h0A;
    else if (r < 70) return 8'h0D;
    else if (r < 85) return 8'h08;
    else if (r < 90) return 8'h7F;
    else if (r < 95) return 8'($urandom_range(0, 31));
    else             return 8'($urandom_range(128, 255));
  endfunction

  task automatic cyc(input bit rn, input bit vld, input logic [7:0] ch, input bit clr);
    bit rdy;
    reset         = rn;
    clear_req     = clr;
    bus.in_valid  = vld;
    bus.in_char   = ch;
    rdy = rn && !m_busy && !clr;
    #1;
    chk("in_ready", bus.in_ready, rdy);
    e_we   = 1'b0;
    e_data = 1'b0;
    if (!rn) begin
      mpos   = 0;
      m_busy = 1'b0;
      m_cnt  = 0;
      e_data = 1'b1;
      e_addr = 0;
      e_din  = 0;
    end else if (m_busy) begin
      e_we   = 1'b1;
      e_addr = m_cnt;
      e_din  = 8'h20;
      if (m_cnt == CELLS - 1) begin
        m_busy = 1'b0;
        mpos   = 0;
      end
      m_cnt++;
    end else if (clr) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end else if (vld) begin
      if (ch >= 8'h20 && ch <= 8'h7E) begin
        e_we   = 1'b1;
        e_addr = mpos;
        e_din  = ch;
        mpos   = (mpos + 1) % CELLS;
      end else if (ch == 8'h0A) begin
        mpos = ((mpos / COLS + 1) % ROWS) * COLS;
      end else if (ch == 8'h0D) begin
        mpos = (mpos / COLS) * COLS;
      end else if (ch == 8'h08 && mpos > 0) begin
        mpos   = mpos - 1;
        e_we   = 1'b1;
        e_addr = mpos;
        e_din  = 8'h20;
      end
    end
    if (e_we) e_data = 1'b1;
    @(posedge clk);
    #1;
    chk("mem_we", bus.mem_we, e_we);
    if (e_data) begin
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_din", bus.mem_din, e_din);
    end
    chk("busy", busy, m_busy);
    chk("cursor_x", cursor_x, mpos % COLS);
    chk("cursor_y", cursor_y, mpos / COLS);
    if (bus.mem_we) seen_we++;
    if (busy) seen_busy++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;

    // Reset, then a single printable character
    cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'h41, 0);
    cyc(1, 1, 8'h41, 0);
    chk("A_we", bus.mem_we, 1);
    chk("A_addr", bus.mem_addr, 0);
    chk("A_din", bus.mem_din, 8'h41);
    chk("A_x", cursor_x, 1);
    chk("A_y", cursor_y, 0);

    // End-of-row and end-of-screen wrap
    cyc(0, 0, 8'h00, 0);
    repeat (159) cyc(1, 1, rand_print(), 0);
    cyc(1, 1, 8'h42, 0);
    chk("B_addr", bus.mem_addr, 159);
    chk("B_x", cursor_x, 0);
    chk("B_y", cursor_y, 1);
    cyc(0, 0, 8'h00, 0);
    repeat (127) cyc(1, 1, 8'h0A, 0);
    repeat (159) cyc(1, 1, rand_print(), 0);
    cyc(1, 1, 8'h43, 0);
    chk("C_addr", bus.mem_addr, 20479);
    chk("C_x", cursor_x, 0);
    chk("C_y", cursor_y, 0);

    // LF then BS across a row boundary
    cyc(0, 0, 8'h00, 0);
    repeat (3) cyc(1, 1, 8'h0A, 0);
    repeat (5) cyc(1, 1, rand_print(), 0);
    cyc(1, 1, 8'h0A, 0);
    chk("LF_we", bus.mem_we, 0);
    chk("LF_x", cursor_x, 0);
    chk("LF_y", cursor_y, 4);
    cyc(1, 1, 8'h08, 0);
    chk("BS_we", bus.mem_we, 1);
    chk("BS_addr", bus.mem_addr, 639);
    chk("BS_din", bus.mem_din, 8'h20);
    chk("BS_x", cursor_x, 159);
    chk("BS_y", cursor_y, 3);

    // Full clear with a colliding character and stray requests during the sweep
    seen_we   = 0;
    seen_busy = 0;
    cyc(1, 1, 8'h58, 1);
    repeat (CELLS) cyc(1, 1'($urandom_range(0, 1)), rand_char(), 1'($urandom_range(0, 1)));
    cyc(1, 0, 8'h00, 0);
    chk("clr_busy_cycles", seen_busy, CELLS);
    chk("clr_writes", seen_we, CELLS);
    chk("clr_x", cursor_x, 0);
    chk("clr_y", cursor_y, 0);
    chk("clr_ready", bus.in_ready, 1);

    // Reset aborts a clear in progress
    repeat (7) cyc(1, 1, rand_print(), 0);
    cyc(1, 0, 8'h00, 1);
    repeat (100) cyc(1, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    chk("abort_we", bus.mem_we, 0);
    chk("abort_busy", busy, 0);
    cyc(1, 0, 8'h00, 0);
    chk("abort_we2", bus.mem_we, 0);
    cyc(1, 1, 8'h08, 0);
    chk("bs_origin_we", bus.mem_we, 0);
    chk("bs_origin_x", cursor_x, 0);

    // Random character traffic with occasional resets
    repeat (3000) cyc(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 4) != 0), rand_char(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
